muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide engine for the EX stage of the 5-stage pipeline.
- Runs MULT/MULTU/DIV/DIVU iteratively on the SrcAE/SrcBE operands and writes the HI/LO result registers.
- Holds busy high so the hazard unit asserts StallF/StallD and FlushE while an operation is in flight.

---
 rtl/muldiv_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EX stage, writing HI/LO with a fixed or early-out latency.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only when the unit is idle (busy=0, done=0);
  // busy stays high from the accepting edge until the edge that raises done;
  // done is a single-cycle pulse and hi/lo are valid from that cycle onward.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 in_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 early_exit;

  // Operand decode for the capture cycle
  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & srca[WIDTH-1];
    b_neg     = in_signed & srcb[WIDTH-1];
    a_mag     = a_neg ? (~srca + 1'b1) : srca;
    b_mag     = b_neg ? (~srcb + 1'b1) : srcb;
  end

  // Restoring divide step: acc holds {remainder, dividend bits still to shift in}
  always_comb begin
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, opb_q[WIDTH-1:0]};
    q_bit    = ~rem_diff[WIDTH];
  end

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_EARLY_OUT_EN
  // At least one iteration always runs, so the shortest multiply is still 3 cycles.
  assign early_exit = ~is_div_q && (mplier_q == '0) && (cnt_q != CNTW'(WIDTH));
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d   = S_RUN;
          cnt_d     = CNTW'(WIDTH);
          busy_d    = 1'b1;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] && (srcb == '0);
          if (op[1]) begin
            // A zero divisor keeps the raw dividend so it can be returned in hi.
            acc_d    = {{WIDTH{1'b0}}, (srcb == '0) ? srca : a_mag};
            opb_d    = {{WIDTH{1'b0}}, b_mag};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            opb_d    = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if ((cnt_q == '0) || early_exit) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (!is_div_q) begin
            acc_d    = acc_q + (mplier_q[0] ? opb_q : '0);
            opb_d    = {opb_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          end else if (!dz_q) begin
            acc_d = {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], q_bit};
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = dz_q;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule
